// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage in-order pipeline: pause/bubble steering,
// data-memory wait tracking with timeout abort, and saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             imem_valid,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pause_if_id,
  output logic             bubble_if_id,
  output logic             pause_id_ex,
  output logic             bubble_id_ex,
  output logic             pause_ex_mem,
  output logic             bubble_ex_mem,
  output logic             pause_mem_wb,
  output logic             bubble_mem_wb,
  output logic             pc_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       mem_stall;
  logic       load_use;
  logic       redirect_act;
  logic [3:0] pause_vec;   // [0]=IF/ID [1]=ID/EX [2]=EX/MEM [3]=MEM/WB
  logic [3:0] bubble_vec;
  logic       pc_hold_c;
  logic       mem_err_c;

  assign mem_stall = mem_req & ~mem_ack;
  assign load_use  = ex_is_load & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // EX is frozen across the whole wait, so a redirect seen there is only honoured back in RUN.
  assign redirect_act = resetn & (state_q == RUN) & ~mem_stall & ex_redirect;

  always_comb begin
    pause_vec  = 4'b0000;
    bubble_vec = 4'b0000;
    pc_hold_c  = 1'b0;
    mem_err_c  = 1'b0;
    if (!resetn) begin
      bubble_vec = 4'b1111;
      pc_hold_c  = 1'b1;
    end else if (state_q == ERR) begin
      bubble_vec = 4'b1111;
      pc_hold_c  = 1'b1;
      mem_err_c  = 1'b1;
    end else if (mem_stall) begin
      pause_vec  = 4'b0111;
      bubble_vec = 4'b1000;
      pc_hold_c  = 1'b1;
    end else if (redirect_act) begin
      bubble_vec = 4'b0011;
    end else if (load_use) begin
      pause_vec  = 4'b0001;
      bubble_vec = 4'b0010;
      pc_hold_c  = 1'b1;
    end else if (!imem_valid) begin
      bubble_vec = 4'b0001;
      pc_hold_c  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack || !mem_req) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ERR;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ERR: begin
        state_d = RUN;
        wait_d  = 8'd0;
      end
      default: begin
        state_d = RUN;
        wait_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_hold_c && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect_act && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RUN;
      wait_q      <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pause_if_id   = pause_vec[0];
  assign pause_id_ex   = pause_vec[1];
  assign pause_ex_mem  = pause_vec[2];
  assign pause_mem_wb  = pause_vec[3];
  assign bubble_if_id  = bubble_vec[0];
  assign bubble_id_ex  = bubble_vec[1];
  assign bubble_ex_mem = bubble_vec[2];
  assign bubble_mem_wb = bubble_vec[3];
  assign pc_hold       = pc_hold_c;
  assign mem_err       = mem_err_c;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule
